// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with the carry
// held in a register between steps and a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       fa_s;

    // Next-state, datapath and decoded handshake outputs.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        fa_s    = full_add(a_sr_q[0], b_sr_q[0], carry_q);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately ignored here so captured operands stay intact
                acc_d   = {fa_s[0], acc_q[WIDTH-1:1]};
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d = fa_s[1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_s[0], acc_q[WIDTH-1:1]};
                    co_d    = fa_s[1];
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= {WIDTH{1'b0}};
            b_sr_q  <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder (WIDTH=8) against a+b+cin,
// including handshake timing, ignored starts and asynchronous reset.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    int         n_checks;
    int         n_errors;
    logic [8:0] last_res;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation with timing checks; glitch>0 pulses start (a=b=FF) before that step edge.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin, input int glitch);
        logic [8:0] exp;
        int busy_n, done_at, done_n, overlap, hold_bad;
        exp = {1'b0, ta} + {1'b0, tb_v} + {8'h00, tcin};
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = int'(busy); done_at = 0; done_n = int'(done); overlap = 0; hold_bad = 0;
        if ({co, sum} !== last_res) hold_bad++;
        for (int k = 1; k <= 11; k++) begin
            if (k == glitch) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
            if (busy && done) overlap++;
            if (k < WIDTH && {co, sum} !== last_res) hold_bad++;
        end
        check("busy_cycles", 32'(busy_n), 32'd8);
        check("done_edge", 32'(done_at), 32'd8);
        check("done_pulses", 32'(done_n), 32'd1);
        check("busy_done_overlap", 32'(overlap), 32'd0);
        check("result_hold", 32'(hold_bad), 32'd0);
        check("sum", 32'(sum), 32'(exp[7:0]));
        check("co", 32'(co), 32'(exp[8]));
        last_res = exp;
    endtask

    // Waits for done, bounded; returns edges elapsed or 0 on timeout.
    task automatic wait_done(output int edges);
        edges = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        int e1, e2;
        n_checks = 0; n_errors = 0; last_res = 9'h000;
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        check("rst2_outs", 32'({busy, done, co, sum}), 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("idle_after_rst", 32'({busy, done}), 32'd0);

        do_op(8'h00, 8'h00, 1'b1, 0);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 0);
        do_op(8'h3C, 8'h5A, 1'b0, 3);

        // Back-to-back with start held high through the DONE cycle.
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done(e1);
        check("b2b_first_edges", 32'(e1), 32'd8);
        check("b2b_sum1", 32'(sum), 32'h00);
        check("b2b_co1", 32'(co), 32'd1);
        a = 8'h12; b = 8'h34; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy_again", 32'({busy, done}), 32'b10);
        check("b2b_hold", 32'({co, sum}), 32'h100);
        wait_done(e2);
        check("b2b_spacing", 32'(e2 + 1), 32'd9);
        check("b2b_sum2", 32'(sum), 32'h47);
        check("b2b_co2", 32'(co), 32'd0);
        last_res = 9'h047;
        @(posedge clk); #1;
        check("b2b_single_done", 32'(done), 32'd0);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outs", 32'({busy, done, co, sum}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        last_res = 9'h000;
        do_op(8'h01, 8'h01, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            do_op(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
